// File: rtl/col_streamer_if.sv
// col_streamer_if: pixel-in / column-word-out handshake bundle for col_streamer.
//   master : pixel source + column-word sink side (drives in_pix/in_valid/out_ready)
//   slave  : the transposer (drives in_ready, out_data/out_valid/out_last, tile_cnt)
//   in_pix/in_valid/in_ready        raster-order pixel stream, one pixel per handshake
//   out_data/out_valid/out_ready    LANES*PIX_W column word, row r in bits [PIX_W*r +: PIX_W]
//   out_last                        word is the last column of the tile
//   tile_cnt                        fully drained tiles, wraps at 2^16
interface col_streamer_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 8
);
  logic [PIX_W-1:0]       in_pix;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*PIX_W-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [15:0]            tile_cnt;

  modport master (
    output in_pix, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, tile_cnt
  );

  modport slave (
    input  in_pix, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, tile_cnt
  );
endinterface

// File: rtl/col_streamer.sv
// col_streamer: tile transposer in front of col_buffer.
// Fills a LANES x IMG_W pixel tile in raster order, then drains it one column
// per handshake as a LANES*PIX_W word. Single buffered: filling and draining
// never overlap, so in_ready and out_valid are never high together.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  col_streamer_if.slave (pixel input, column-word output, tile_cnt)
module col_streamer #(
  parameter int PIX_W = 8,
  parameter int LANES = 8,
  parameter int IMG_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  col_streamer_if.slave  bus
);
  localparam int RW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int DW = LANES * PIX_W;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

  state_e            state_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DW-1:0]     out_data_q;
  logic [15:0]       tile_cnt_q;

  logic [PIX_W-1:0]  pix_q [LANES][IMG_W];

  logic              in_acc;
  logic              out_acc;
  logic [CW-1:0]     sel_col;
  logic [DW-1:0]     col_word;

  assign in_acc  = bus.in_valid & in_ready_q;
  assign out_acc = out_valid_q & bus.out_ready;

  // Column to load into out_data on this edge: column 0 when the fill
  // completes, otherwise the column after the one currently presented.
  assign sel_col = (state_q == DRAIN) ? col_q + CW'(1) : '0;

  // The final pixel of a fill lands in the last column, so column 0 is
  // already complete in storage when it is read here.
  for (genvar r = 0; r < LANES; r++) begin : g_lane
    assign col_word[r*PIX_W +: PIX_W] = pix_q[r][sel_col];
  end

  // Pixel storage carries no reset; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_acc) pix_q[row_q][col_q] <= bus.in_pix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      tile_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= FILL;
          in_ready_q <= 1'b1;
        end
        FILL: begin
          if (in_acc) begin
            if (col_q == CW'(IMG_W-1)) begin
              col_q <= '0;
              if (row_q == RW'(LANES-1)) begin
                row_q       <= '0;
                state_q     <= DRAIN;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                out_data_q  <= col_word;
                out_last_q  <= 1'b0;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_acc) begin
            if (out_last_q) begin
              state_q     <= FILL;
              row_q       <= '0;
              col_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              tile_cnt_q  <= tile_cnt_q + 16'd1;
            end else begin
              col_q      <= col_q + CW'(1);
              out_data_q <= col_word;
              out_last_q <= (col_q + CW'(1)) == CW'(IMG_W-1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.tile_cnt  = tile_cnt_q;
endmodule

// File: tb/tb_col_streamer.sv
module tb_col_streamer;
  localparam int PIX_W = 8;
  localparam int LANES = 8;
  localparam int IMG_W = 4;
  localparam int NPIX  = LANES * IMG_W;
  localparam int DW    = LANES * PIX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  col_streamer_if #(.PIX_W(PIX_W), .LANES(LANES)) bus ();
  col_streamer #(.PIX_W(PIX_W), .LANES(LANES), .IMG_W(IMG_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: pixels accepted so far in the current tile, whether the
  // tile is being drained, which column should be presented, tiles done.
  logic [PIX_W-1:0] src[$];
  int               buff[NPIX];
  int               n_in, ecol, tiles, low_cnt;
  bit               drain, started;
  logic [DW-1:0]    seen_w[IMG_W];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word for column c: row r pixel at bits [r*PIX_W +: PIX_W].
  function automatic logic [DW-1:0] exp_word(input int c);
    logic [DW-1:0] w;
    w = '0;
    for (int r = 0; r < LANES; r++) w[r*PIX_W +: PIX_W] = PIX_W'(buff[r*IMG_W + c]);
    return w;
  endfunction

  task automatic load_tile(input int base, input bit rnd);
    for (int k = 0; k < NPIX; k++)
      src.push_back(rnd ? PIX_W'($urandom) : PIX_W'(base + 16*(k / IMG_W) + (k % IMG_W)));
  endtask

  // One clock: drive inputs, predict handshakes from currently visible
  // outputs, advance the model, then check the registered outputs.
  task automatic cyc(input bit iv, input bit ordy);
    bit ai, ao, pv;
    logic [DW-1:0] pd;
    logic [PIX_W-1:0] p;
    bit v;
    v = iv && (src.size() > 0);
    p = v ? src[0] : PIX_W'($urandom);
    bus.in_valid  = v;
    bus.in_pix    = p;
    bus.out_ready = ordy;
    ai = v && bus.in_ready;
    ao = bus.out_valid && ordy;
    pv = bus.out_valid;
    pd = bus.out_data;
    @(posedge clk); #1;
    started = 1;
    if (ai) begin
      buff[n_in] = int'(p);
      n_in++;
      void'(src.pop_front());
      if (n_in == NPIX) begin drain = 1; ecol = 0; end
    end
    if (ao) begin
      if (ecol == IMG_W-1) begin drain = 0; n_in = 0; tiles++; end
      else ecol++;
    end
    chk("in_ready", DW'(bus.in_ready), DW'(!drain && started));
    chk("out_valid", DW'(bus.out_valid), DW'(drain));
    chk("tile_cnt", DW'(bus.tile_cnt), DW'(16'(tiles)));
    if (drain) begin
      chk("out_data", bus.out_data, exp_word(ecol));
      chk("out_last", DW'(bus.out_last), DW'(ecol == IMG_W-1));
      seen_w[ecol] = bus.out_data;
    end else begin
      chk("out_last_idle", DW'(bus.out_last), '0);
    end
    if (pv && !ao) chk("hold_data", bus.out_data, pd);
    if (!bus.in_ready) low_cnt++;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    bus.in_valid  = 1'b1;
    bus.in_pix    = 8'hAA;
    bus.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", DW'(bus.in_ready), '0);
    chk("rst_out_valid", DW'(bus.out_valid), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_tile_cnt", DW'(bus.tile_cnt), '0);
    @(posedge clk); #1;
    chk("rst_hold_in_ready", DW'(bus.in_ready), '0);
    chk("rst_hold_out_last", DW'(bus.out_last), '0);
    rst = 1'b0;
    n_in = 0; drain = 0; tiles = 0; started = 0; ecol = 0;
    src.delete();
  endtask

  // ivm: 0 always valid, 1 toggle, 2 random. orm: 0 ready, 1 stall 5 at word 1, 2 random.
  task automatic run(input int target, input int ivm, input int orm, input int budget);
    int n;
    int bp;
    bit iv, ordy;
    n = 0; bp = 0;
    while (tiles < target && n < budget) begin
      iv = (ivm == 0) ? 1'b1 : (ivm == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      if (orm == 1) begin
        ordy = 1'b1;
        if (drain && ecol == 1 && bp < 5) begin ordy = 1'b0; bp++; end
      end else begin
        ordy = (orm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      cyc(iv, ordy);
      n++;
    end
    chk("budget", DW'(tiles >= target), DW'(1));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_pix = '0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Basic transpose with in_ready low for exactly IMG_W cycles.
    load_tile(0, 0);
    low_cnt = 0;
    cyc(1, 1);                 // IDLE -> FILL edge, nothing accepted
    low_cnt = 0;
    run(1, 0, 0, 200);
    chk("ready_low_cycles", DW'(low_cnt), DW'(IMG_W));
    chk("word0_const", seen_w[0], 64'h7060504030201000);
    chk("word3_const", seen_w[3], 64'h7363534333231303);

    // Input bubbles on the same tile.
    do_reset();
    load_tile(0, 0);
    run(1, 1, 0, 400);
    chk("bubble_word1", seen_w[1], 64'h7161514131211101);

    // Backpressure at word 1.
    do_reset();
    load_tile(0, 0);
    run(1, 0, 1, 200);

    // Back-to-back tiles, second offset by 0x80.
    do_reset();
    load_tile(0, 0);
    load_tile(8'h80, 0);
    run(2, 0, 0, 400);
    chk("b2b_word2", seen_w[2], 64'hF2E2D2C2B2A29282);

    // Mid-fill reset after 20 pixels.
    do_reset();
    load_tile(0, 0);
    for (int i = 0; i < 21; i++) cyc(1, 1);
    chk("mid_fill_count", DW'(bus.in_ready), DW'(1));
    do_reset();

    // Mid-drain reset during word 2, then a fresh tile.
    load_tile(0, 0);
    for (int i = 0; i < 200 && !(drain && ecol == 2); i++) cyc(1, 1);
    chk("reached_word2", DW'(drain && ecol == 2), DW'(1));
    do_reset();
    load_tile(0, 0);
    run(1, 0, 0, 200);

    // Random pixels and random handshakes on both sides.
    do_reset();
    for (int t = 0; t < 4; t++) load_tile(0, 1);
    run(4, 2, 2, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
